// File: rtl/excitatory_synapse_bank.sv
// excitatory_synapse_bank: per-channel weight-length excitation pulses from edge events,
// with a registered active-channel sum and a saturating accepted-event counter.
module excitatory_synapse_bank #(
   parameter int NUM_CH = 4,
   parameter int W_W = 4,
   parameter bit RETRIGGER = 1'b1,
   parameter int EVT_W = 8,
   localparam int SUM_W = $clog2(NUM_CH + 1)
) (
   input  logic                    clk,
   input  logic                    reset_i,
   input  logic                    enable_i,
   input  logic [NUM_CH-1:0]       edge_i,
   input  logic [NUM_CH*W_W-1:0]   weight_i,
   output logic [NUM_CH-1:0]       excited_o,
   output logic [SUM_W-1:0]        excite_sum_o,
   output logic [EVT_W-1:0]        event_cnt_o
);
   localparam int T_W = EVT_W + SUM_W;
   logic [W_W-1:0]    cnt [NUM_CH];
   logic [NUM_CH-1:0] acc;
   logic [SUM_W-1:0]  acc_pop;
   logic [SUM_W-1:0]  exc_pop;
   logic [T_W-1:0]    evt_nxt;
   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_exc
         assign excited_o[g] = |cnt[g];
      end
   endgenerate
   // zero weight disables a channel; without retrigger a busy channel drops edges
   always_comb begin
      acc = '0;
      acc_pop = '0;
      exc_pop = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         acc[k] = edge_i[k] & enable_i & (|weight_i[k*W_W +: W_W]) & (~excited_o[k] | RETRIGGER);
         acc_pop = acc_pop + SUM_W'(acc[k]);
         exc_pop = exc_pop + SUM_W'(excited_o[k]);
      end
      evt_nxt = T_W'(event_cnt_o) + T_W'(acc_pop);
   end
   always_ff @(posedge clk) begin
      if (reset_i) begin
         for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
         excite_sum_o <= '0;
         event_cnt_o <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++)
            cnt[k] <= acc[k] ? weight_i[k*W_W +: W_W] : (excited_o[k] ? cnt[k] - 1'b1 : cnt[k]);
         excite_sum_o <= exc_pop;
         event_cnt_o <= (|evt_nxt[T_W-1:EVT_W]) ? {EVT_W{1'b1}} : evt_nxt[EVT_W-1:0];
      end
   end
endmodule

// File: tb/tb_excitatory_synapse_bank.sv
// tb_excitatory_synapse_bank: directed checks of pulse stretching, retrigger modes, gating,
// reset abort and event-count saturation on three differently parameterised instances.
module tb_excitatory_synapse_bank;
   logic        clk = 1'b0;
   logic        reset_i;
   logic        enable_i;
   logic [3:0]  edge_i;
   logic [15:0] weight_i;
   logic [3:0]  exc_a, exc_b, exc_c;
   logic [2:0]  sum_a, sum_b, sum_c;
   logic [7:0]  evt_a, evt_b;
   logic [3:0]  evt_c;
   int n_chk = 0;
   int n_fail = 0;
   always #5 clk = ~clk;
   excitatory_synapse_bank #(.NUM_CH(4), .W_W(4), .RETRIGGER(1'b1), .EVT_W(8)) dut_a (
      .clk(clk), .reset_i(reset_i), .enable_i(enable_i), .edge_i(edge_i), .weight_i(weight_i),
      .excited_o(exc_a), .excite_sum_o(sum_a), .event_cnt_o(evt_a));
   excitatory_synapse_bank #(.NUM_CH(4), .W_W(4), .RETRIGGER(1'b0), .EVT_W(8)) dut_b (
      .clk(clk), .reset_i(reset_i), .enable_i(enable_i), .edge_i(edge_i), .weight_i(weight_i),
      .excited_o(exc_b), .excite_sum_o(sum_b), .event_cnt_o(evt_b));
   excitatory_synapse_bank #(.NUM_CH(4), .W_W(4), .RETRIGGER(1'b1), .EVT_W(4)) dut_c (
      .clk(clk), .reset_i(reset_i), .enable_i(enable_i), .edge_i(edge_i), .weight_i(weight_i),
      .excited_o(exc_c), .excite_sum_o(sum_c), .event_cnt_o(evt_c));
   task automatic do_reset;
      reset_i = 1'b1;
      edge_i = '0;
      enable_i = 1'b1;
      repeat (2) @(negedge clk);
      reset_i = 1'b0;
   endtask
   task automatic test_reset;
      reset_i = 1'b1;
      enable_i = 1'b1;
      edge_i = 4'b1111;
      weight_i = 16'h3333;
      repeat (3) @(negedge clk);
      n_chk++; if (exc_a !== 4'b0) begin n_fail++; $display("FAIL reset exc_a got %b want 0000", exc_a); end
      n_chk++; if (sum_a !== 3'd0) begin n_fail++; $display("FAIL reset sum_a got %0d want 0", sum_a); end
      n_chk++; if (evt_a !== 8'd0) begin n_fail++; $display("FAIL reset evt_a got %0d want 0", evt_a); end
      n_chk++; if (exc_b !== 4'b0) begin n_fail++; $display("FAIL reset exc_b got %b want 0000", exc_b); end
      n_chk++; if (evt_c !== 4'd0) begin n_fail++; $display("FAIL reset evt_c got %0d want 0", evt_c); end
      reset_i = 1'b0;
      edge_i = '0;
      repeat (3) begin
         @(negedge clk);
         n_chk++; if (exc_a !== 4'b0 || sum_a !== 3'd0 || evt_a !== 8'd0) begin
            n_fail++; $display("FAIL idle got exc=%b sum=%0d evt=%0d want 0/0/0", exc_a, sum_a, evt_a);
         end
      end
   endtask
   task automatic test_stretch;
      logic [3:0] ee [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
      logic [2:0] es [5] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd0};
      do_reset();
      weight_i = 16'h0003;
      edge_i = 4'b0001;
      @(negedge clk);
      edge_i = '0;
      for (int i = 0; i < 5; i++) begin
         n_chk++; if (exc_a !== ee[i]) begin n_fail++; $display("FAIL stretch exc c%0d got %b want %b", 11 + i, exc_a, ee[i]); end
         n_chk++; if (sum_a !== es[i]) begin n_fail++; $display("FAIL stretch sum c%0d got %0d want %0d", 11 + i, sum_a, es[i]); end
         n_chk++; if (evt_a !== 8'd1) begin n_fail++; $display("FAIL stretch evt c%0d got %0d want 1", 11 + i, evt_a); end
         @(negedge clk);
      end
   endtask
   task automatic test_retrigger;
      logic ea [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic eb [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      do_reset();
      weight_i = 16'h0004;
      edge_i = 4'b0001;
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         edge_i = (i == 1) ? 4'b0001 : 4'b0000;
         n_chk++; if (exc_a[0] !== ea[i]) begin n_fail++; $display("FAIL retrig_on c%0d got %b want %b", 11 + i, exc_a[0], ea[i]); end
         n_chk++; if (exc_b[0] !== eb[i]) begin n_fail++; $display("FAIL retrig_off c%0d got %b want %b", 11 + i, exc_b[0], eb[i]); end
         @(negedge clk);
      end
      n_chk++; if (evt_a !== 8'd2) begin n_fail++; $display("FAIL retrig_on evt got %0d want 2", evt_a); end
      n_chk++; if (evt_b !== 8'd1) begin n_fail++; $display("FAIL retrig_off evt got %0d want 1", evt_b); end
   endtask
   task automatic test_last_high_drop;
      do_reset();
      weight_i = 16'h0004;
      edge_i = 4'b0001;
      @(negedge clk);
      edge_i = '0;
      repeat (3) @(negedge clk);
      edge_i = 4'b0001;
      n_chk++; if (exc_b[0] !== 1'b1) begin n_fail++; $display("FAIL lasthigh c14 got %b want 1", exc_b[0]); end
      @(negedge clk);
      edge_i = '0;
      n_chk++; if (exc_b[0] !== 1'b0) begin n_fail++; $display("FAIL lasthigh_off c15 got %b want 0", exc_b[0]); end
      n_chk++; if (evt_b !== 8'd1) begin n_fail++; $display("FAIL lasthigh_off evt got %0d want 1", evt_b); end
      n_chk++; if (exc_a[0] !== 1'b1) begin n_fail++; $display("FAIL lasthigh_on c15 got %b want 1", exc_a[0]); end
      n_chk++; if (evt_a !== 8'd2) begin n_fail++; $display("FAIL lasthigh_on evt got %0d want 2", evt_a); end
   endtask
   task automatic test_concurrency;
      logic [3:0] ee [5] = '{4'b0111, 4'b0110, 4'b0100, 4'b0000, 4'b0000};
      logic [2:0] es [5] = '{3'd0, 3'd3, 3'd2, 3'd1, 3'd0};
      do_reset();
      weight_i = {4'd0, 4'd3, 4'd2, 4'd1};
      edge_i = 4'b1111;
      @(negedge clk);
      edge_i = '0;
      for (int i = 0; i < 5; i++) begin
         n_chk++; if (exc_a !== ee[i]) begin n_fail++; $display("FAIL conc exc c%0d got %b want %b", 21 + i, exc_a, ee[i]); end
         n_chk++; if (sum_a !== es[i]) begin n_fail++; $display("FAIL conc sum c%0d got %0d want %0d", 21 + i, sum_a, es[i]); end
         @(negedge clk);
      end
      n_chk++; if (evt_a !== 8'd3) begin n_fail++; $display("FAIL conc evt got %0d want 3", evt_a); end
      enable_i = 1'b0;
      edge_i = 4'b1111;
      repeat (4) begin
         @(negedge clk);
         n_chk++; if (exc_a !== 4'b0 || sum_a !== 3'd0) begin
            n_fail++; $display("FAIL gated got exc=%b sum=%0d want 0000/0", exc_a, sum_a);
         end
      end
      n_chk++; if (evt_a !== 8'd3) begin n_fail++; $display("FAIL gated evt got %0d want 3", evt_a); end
      edge_i = '0;
      enable_i = 1'b1;
   endtask
   task automatic test_weight_change_and_abort;
      do_reset();
      weight_i = 16'h0005;
      edge_i = 4'b0001;
      @(negedge clk);
      edge_i = '0;
      weight_i = 16'h0001;
      for (int i = 0; i < 6; i++) begin
         n_chk++; if (exc_a[0] !== (i < 5)) begin n_fail++; $display("FAIL wchange c%0d got %b want %b", 31 + i, exc_a[0], i < 5); end
         @(negedge clk);
      end
      do_reset();
      weight_i = 16'h0005;
      edge_i = 4'b0001;
      @(negedge clk);
      edge_i = '0;
      @(negedge clk);
      n_chk++; if (exc_a[0] !== 1'b1) begin n_fail++; $display("FAIL abort c32 got %b want 1", exc_a[0]); end
      @(negedge clk);
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      n_chk++; if (exc_a !== 4'b0 || sum_a !== 3'd0 || evt_a !== 8'd0) begin
         n_fail++; $display("FAIL abort c34 got exc=%b sum=%0d evt=%0d want 0/0/0", exc_a, sum_a, evt_a);
      end
      @(negedge clk);
      n_chk++; if (exc_a !== 4'b0) begin n_fail++; $display("FAIL abort c35 got %b want 0000", exc_a); end
   endtask
   task automatic test_saturation;
      int ea, ec, eb;
      do_reset();
      weight_i = 16'h1111;
      for (int k = 0; k < 5; k++) begin
         edge_i = 4'b1111;
         @(negedge clk);
         ea = 4 * (k + 1);
         ec = (ea > 15) ? 15 : ea;
         eb = 4 * (k / 2 + 1);
         n_chk++; if (evt_a !== ea[7:0]) begin n_fail++; $display("FAIL sat evt_a burst%0d got %0d want %0d", k, evt_a, ea); end
         n_chk++; if (evt_c !== ec[3:0]) begin n_fail++; $display("FAIL sat evt_c burst%0d got %0d want %0d", k, evt_c, ec); end
         n_chk++; if (evt_b !== eb[7:0]) begin n_fail++; $display("FAIL sat evt_b burst%0d got %0d want %0d", k, evt_b, eb); end
      end
      repeat (3) begin
         edge_i = 4'b0001;
         @(negedge clk);
         edge_i = '0;
         @(negedge clk);
      end
      n_chk++; if (evt_c !== 4'd15) begin n_fail++; $display("FAIL sat hold evt_c got %0d want 15", evt_c); end
      n_chk++; if (evt_a !== 8'd23) begin n_fail++; $display("FAIL sat evt_a final got %0d want 23", evt_a); end
   endtask
   initial begin
      reset_i = 1'b1;
      enable_i = 1'b1;
      edge_i = '0;
      weight_i = '0;
      @(negedge clk);
      test_reset();
      test_stretch();
      test_retrigger();
      test_last_high_drop();
      test_concurrency();
      test_weight_change_and_abort();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
